ad9122_spi_slave_regfile: RTL and testbench
===========================================

Name: ad9122_spi_slave_regfile

Overview:
- Synthesizable responder for the AD9122 3-wire SPI port.
- Sits opposite the DAC configuration master in closed-loop simulation, and serves as an FPGA-side DAC register model.
- Oversamples SCLK/SEN_N/SDIO in the system clock domain and decodes 16-bit frames: bit15 R/W, bits14:8 address, bits7:0 data, MSB first.
- Holds a 128x8 register file, drives read data back on SDIO, and models soft reset and FIFO soft-align acknowledge.

Parameters:
- SYNC_STAGES, 2, synchronizer depth on i_sclk/i_sen_n/i_sda (legal range 2..4).
- ALIGN_LAT, 16, clk_in cycles from a 0x18 align-request write to the 0x18 ack becoming visible (legal range 1..65535).
- SOFT_RST_LEN, 4, width in clk_in cycles of the o_soft_rst pulse.

Ports:
- clk_in  input  1  system clock; must be at least 8x the SCLK frequency.
- rst_n  input  1  synchronous, active-low reset.
- i_sclk  input  1  SPI clock from master; idles low (mode 0).
- i_sen_n  input  1  SPI chip select, active low.
- i_sda  input  1  SDIO value as seen at the pad.
- o_sda  output  1  read data to be driven onto SDIO.
- o_sda_dir  output  1  1 = slave drives SDIO, 0 = high-Z.
- o_wr_valid  output  1  one-cycle pulse on every committed register write.
- o_wr_addr  output  7  address of the committed write.
- o_wr_data  output  8  data of the committed write.
- o_soft_rst  output  1  soft-reset pulse.
- i_fifo_status  input  8  live value returned on reads of address 0x19.

Behaviour:
- Reset: all outputs 0; register file all 0x00; FSM in IDLE; bit counter 0; align timer idle.
- Input conditioning: each input passes through SYNC_STAGES flops. Edge detect on synced SCLK gives rise/fall strobes; rising edge of synced SEN_N gives the frame-end strobe.
- Sampling: i_sda is sampled on SCLK rise strobes. o_sda changes only on SCLK fall strobes.
- States:
  - IDLE: wait for synced SEN_N = 0, then go to INSTR with bit count = 0.
  - INSTR: shift in 8 bits. After the 8th rise, latch R/W and address. R/W = 0 goes to WDATA. R/W = 1 goes to RDATA and loads the shift-out register with the read value at that moment.
  - WDATA: shift in 8 bits. On the 8th rise, commit on the next cycle: write the register, pulse o_wr_valid with addr/data for 1 cycle, then go to DONE.
  - RDATA: on the first fall after entry, set o_sda_dir = 1 and o_sda = bit7. Each following fall shifts out the next bit, MSB first. On the 8th rise go to DONE. o_sda_dir stays 1 until the frame-end strobe.
  - DONE: ignore further SCLK edges. On the frame-end strobe: o_sda_dir = 0, go to IDLE.
- Abort: a frame-end strobe in INSTR, WDATA or RDATA aborts the frame.
  - No write and no o_wr_valid.
  - o_sda_dir = 0 in the same cycle; return to IDLE.
- Register semantics:
  - Address 0x00, bit7 written as 1 (soft reset):
    - All registers 0x01..0x7F clear to 0x00.
    - 0x00 takes the written data & 0x7F.
    - o_soft_rst is high for SOFT_RST_LEN cycles, starting with the commit cycle.
    - The align timer is cancelled.
  - Address 0x18:
    - Write with bit1 = 1 stores the data and starts the align timer.
    - After ALIGN_LAT cycles, 0x18 reads 0x07.
    - Write 0x00 clears the register and cancels any running timer.
    - A new request while the timer runs restarts it.
  - Address 0x19: read-only. Reads return i_fifo_status sampled at the 8th instruction rise. Writes are discarded, but o_wr_valid still pulses.
  - All other addresses: plain read/write storage.
- Simultaneous events: a commit and an align-timer expiry in the same cycle resolve with the commit winning for address 0x18.
- Reset mid-frame: everything returns to reset values. The next frame is decoded only after SEN_N is seen high and then low.

Optional Feature:
- Macro: AD9122_SPI_SLV_ERR_CNT_EN.
- Defined:
  - Adds output o_err_cnt [7:0], which counts aborted frames and saturates at 0xFF.
  - Cleared by rst_n only; unaffected by soft reset.
  - Also counts SCLK rise strobes seen in DONE as errors, at most one count per frame.
- Undefined: the port and the counter are absent, and behaviour is otherwise identical.

Test Plan:
- Write 0x08=0xA0, then read 0x08 -> one o_wr_valid pulse with addr 0x08/data 0xA0; read returns 0xA0; o_sda_dir high from the 8th fall to SEN_N high.
- Write 0x16=0x02, then write 0x00=0x80 -> o_soft_rst high for 4 cycles; read 0x16 returns 0x00; read 0x00 returns 0x00.
- Write 0x18=0x02, read 0x18 at once, then read again after more than 16 cycles -> first read returns 0x02, later read returns 0x07; write 0x18=0x00 -> read returns 0x00.
- Drive i_fifo_status=0x1F, read 0x19 -> 0x1F; write 0x19=0x55 -> read still follows i_fifo_status.
- Raise SEN_N after 12 bits of a write to 0x30 -> no o_wr_valid; 0x30 unchanged; error count +1 when the macro is defined.
- Pulse rst_n low during RDATA -> o_sda_dir=0 next cycle; the next full frame decodes correctly.

Source files
------------

// File: rtl/ad9122_spi_slave_regfile_if.sv
// Bus bundle for the AD9122 3-wire SPI responder: SPI pins, write-commit port, status.
// o_err_cnt exists only when AD9122_SPI_SLV_ERR_CNT_EN is defined.
interface ad9122_spi_slave_regfile_if;
  logic       i_sclk;
  logic       i_sen_n;
  logic       i_sda;
  logic       o_sda;
  logic       o_sda_dir;
  logic       o_wr_valid;
  logic [6:0] o_wr_addr;
  logic [7:0] o_wr_data;
  logic       o_soft_rst;
  logic [7:0] i_fifo_status;
`ifdef AD9122_SPI_SLV_ERR_CNT_EN
  logic [7:0] o_err_cnt;
`endif

  modport slave (
    input  i_sclk, i_sen_n, i_sda, i_fifo_status,
    output o_sda, o_sda_dir, o_wr_valid, o_wr_addr, o_wr_data, o_soft_rst
`ifdef AD9122_SPI_SLV_ERR_CNT_EN
    , output o_err_cnt
`endif
  );

  modport master (
    output i_sclk, i_sen_n, i_sda, i_fifo_status,
    input  o_sda, o_sda_dir, o_wr_valid, o_wr_addr, o_wr_data, o_soft_rst
`ifdef AD9122_SPI_SLV_ERR_CNT_EN
    , input o_err_cnt
`endif
  );
endinterface

// File: rtl/ad9122_spi_slave_regfile.sv
// AD9122 3-wire SPI responder: oversampled frame decode, 128x8 register file, soft reset, align ack.
// Optional aborted-frame counter (o_err_cnt) enabled by defining AD9122_SPI_SLV_ERR_CNT_EN.
module ad9122_spi_slave_regfile #(
  parameter int unsigned SYNC_STAGES  = 2,
  parameter int unsigned ALIGN_LAT    = 16,
  parameter int unsigned SOFT_RST_LEN = 4
) (
  input logic                       clk_in,
  input logic                       rst_n,
  ad9122_spi_slave_regfile_if.slave bus
);
  localparam logic [6:0] SOFT_ADDR  = 7'h00;
  localparam logic [6:0] ALIGN_ADDR = 7'h18;
  localparam logic [6:0] FIFO_ADDR  = 7'h19;

  typedef enum logic [2:0] {IDLE, INSTR, WDATA, RDATA, DONE} state_t;
  state_t state_q, state_d;

  logic [SYNC_STAGES-1:0] sclk_sync_q, sen_sync_q, sda_sync_q;
  logic       sclk_prev_q, sen_prev_q, armed_q;
  logic       sclk_s, sen_s, sda_s, sclk_rise, sclk_fall, frame_end, last_bit, abort, wdata_done;
  logic [2:0] bit_cnt_q;
  logic [7:0] shift_q, shift_in, tx_q, rd_val;
  logic [6:0] addr_q;
  logic       sda_q, sda_dir_q;
  logic       commit_q;
  logic [6:0] cmt_addr_q;
  logic [7:0] cmt_data_q;
  logic [15:0] soft_cnt_q;
  logic [7:0] regs_q [128];
  logic       align_busy_q;
  logic [15:0] align_cnt_q;

  always_ff @(posedge clk_in) begin
    if (!rst_n) begin
      sclk_sync_q <= '0;
      sen_sync_q  <= '0;
      sda_sync_q  <= '0;
      sclk_prev_q <= 1'b0;
      sen_prev_q  <= 1'b0;
      armed_q     <= 1'b0;
    end else begin
      sclk_sync_q <= {sclk_sync_q[SYNC_STAGES-2:0], bus.i_sclk};
      sen_sync_q  <= {sen_sync_q[SYNC_STAGES-2:0], bus.i_sen_n};
      sda_sync_q  <= {sda_sync_q[SYNC_STAGES-2:0], bus.i_sda};
      sclk_prev_q <= sclk_s;
      sen_prev_q  <= sen_s;
      // A frame may start only once SEN_N has been seen high since reset.
      if (sen_s) armed_q <= 1'b1;
    end
  end

  assign sclk_s     = sclk_sync_q[SYNC_STAGES-1];
  assign sen_s      = sen_sync_q[SYNC_STAGES-1];
  assign sda_s      = sda_sync_q[SYNC_STAGES-1];
  assign sclk_rise  = sclk_s & ~sclk_prev_q;
  assign sclk_fall  = ~sclk_s & sclk_prev_q;
  assign frame_end  = sen_s & ~sen_prev_q;
  assign shift_in   = {shift_q[6:0], sda_s};
  assign last_bit   = sclk_rise && (bit_cnt_q == 3'd7);
  assign abort      = frame_end && (state_q inside {INSTR, WDATA, RDATA});
  assign wdata_done = (state_q == WDATA) && last_bit && !frame_end;
  assign rd_val     = (shift_in[6:0] == FIFO_ADDR) ? bus.i_fifo_status : regs_q[shift_in[6:0]];

  always_ff @(posedge clk_in) begin
    if (!rst_n) state_q <= IDLE;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:  if (armed_q && !sen_s) state_d = INSTR;
      INSTR: if (frame_end)     state_d = IDLE;
             else if (last_bit) state_d = shift_in[7] ? RDATA : WDATA;
      WDATA,
      RDATA: if (frame_end)     state_d = IDLE;
             else if (last_bit) state_d = DONE;
      DONE:  if (frame_end)     state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk_in) begin
    if (!rst_n) begin
      bit_cnt_q  <= '0;
      shift_q    <= '0;
      addr_q     <= '0;
      tx_q       <= '0;
      sda_q      <= 1'b0;
      sda_dir_q  <= 1'b0;
      commit_q   <= 1'b0;
      cmt_addr_q <= '0;
      cmt_data_q <= '0;
      soft_cnt_q <= '0;
    end else begin
      commit_q <= 1'b0;
      if (state_q == IDLE) begin
        bit_cnt_q <= '0;
      end else if ((state_q inside {INSTR, WDATA, RDATA}) && sclk_rise) begin
        bit_cnt_q <= bit_cnt_q + 3'd1;
        shift_q   <= shift_in;
      end
      if (state_q == INSTR && last_bit) begin
        addr_q <= shift_in[6:0];
        if (shift_in[7]) tx_q <= rd_val;
      end
      // Commit is registered so it lands one cycle after the 8th data rise.
      if (wdata_done) begin
        commit_q   <= 1'b1;
        cmt_addr_q <= addr_q;
        cmt_data_q <= shift_in;
      end
      if (wdata_done && addr_q == SOFT_ADDR && shift_in[7])
        soft_cnt_q <= SOFT_RST_LEN[15:0];
      else if (soft_cnt_q != '0)
        soft_cnt_q <= soft_cnt_q - 16'd1;
      if (state_q == RDATA && sclk_fall) begin
        sda_dir_q <= 1'b1;
        sda_q     <= tx_q[7];
        tx_q      <= {tx_q[6:0], 1'b0};
      end
      if (frame_end && state_q != IDLE) begin
        sda_dir_q <= 1'b0;
        sda_q     <= 1'b0;
      end
    end
  end

  always_ff @(posedge clk_in) begin
    if (!rst_n) begin
      for (int unsigned i = 0; i < 128; i++) regs_q[i[6:0]] <= '0;
      align_busy_q <= 1'b0;
      align_cnt_q  <= '0;
    end else begin
      if (align_busy_q) begin
        if (align_cnt_q == 16'd1) begin
          regs_q[ALIGN_ADDR] <= 8'h07;
          align_busy_q       <= 1'b0;
        end
        align_cnt_q <= align_cnt_q - 16'd1;
      end
      // Placed after the expiry update so a same-cycle commit to 0x18 wins.
      if (commit_q) begin
        if (cmt_addr_q == SOFT_ADDR && cmt_data_q[7]) begin
          for (int unsigned i = 1; i < 128; i++) regs_q[i[6:0]] <= '0;
          regs_q[SOFT_ADDR] <= cmt_data_q & 8'h7F;
          align_busy_q      <= 1'b0;
        end else if (cmt_addr_q != FIFO_ADDR) begin
          regs_q[cmt_addr_q] <= cmt_data_q;
          if (cmt_addr_q == ALIGN_ADDR) begin
            if (cmt_data_q == 8'h00) begin
              align_busy_q <= 1'b0;
            end else if (cmt_data_q[1]) begin
              align_busy_q <= 1'b1;
              align_cnt_q  <= ALIGN_LAT[15:0];
            end
          end
        end
      end
    end
  end

`ifdef AD9122_SPI_SLV_ERR_CNT_EN
  logic [7:0] err_cnt_q;
  logic       done_err_q;

  always_ff @(posedge clk_in) begin
    if (!rst_n) begin
      err_cnt_q  <= '0;
      done_err_q <= 1'b0;
    end else begin
      if (state_q != DONE) done_err_q <= 1'b0;
      if (abort) begin
        if (err_cnt_q != 8'hFF) err_cnt_q <= err_cnt_q + 8'd1;
      end else if (state_q == DONE && sclk_rise && !done_err_q) begin
        done_err_q <= 1'b1;
        if (err_cnt_q != 8'hFF) err_cnt_q <= err_cnt_q + 8'd1;
      end
    end
  end

  assign bus.o_err_cnt = err_cnt_q;
`endif

  assign bus.o_sda      = sda_q;
  assign bus.o_sda_dir  = sda_dir_q & ~frame_end;
  assign bus.o_wr_valid = commit_q;
  assign bus.o_wr_addr  = cmt_addr_q;
  assign bus.o_wr_data  = cmt_data_q;
  assign bus.o_soft_rst = (soft_cnt_q != '0);
endmodule

// File: tb/tb_ad9122_spi_slave_regfile.sv
// Bench for ad9122_spi_slave_regfile: vector table of SPI frames plus hand sequences
// for soft reset, align ack timing, frame abort and reset during a read.
module tb_ad9122_spi_slave_regfile;
  localparam int unsigned HALF         = 8;
  localparam int unsigned ALIGN_LAT_TB = 200;

  logic clk_in = 1'b0;
  logic rst_n  = 1'b0;
  always #5 clk_in = ~clk_in;

  ad9122_spi_slave_regfile_if bus ();

  ad9122_spi_slave_regfile #(
    .SYNC_STAGES (2),
    .ALIGN_LAT   (ALIGN_LAT_TB),
    .SOFT_RST_LEN(4)
  ) dut (
    .clk_in(clk_in),
    .rst_n (rst_n),
    .bus   (bus)
  );

  typedef struct {
    bit       rw;
    bit [6:0] addr;
    bit [7:0] data;   // write data, or expected read data
    bit [7:0] fifo;
  } vec_t;

  int unsigned n_checks = 0;
  int unsigned n_pass   = 0;
  int unsigned soft_cycles = 0;
  logic [14:0] wq[$];
  logic [7:0]  rq[$];
  logic dir_pre, dir_mid, dir_end, dir_post;

  function automatic void check(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", name, got, exp);
  endfunction

  // Write-commit monitor pops the expected write pushed when the frame was driven.
  always @(negedge clk_in) begin
    if (rst_n && bus.o_soft_rst) soft_cycles++;
    if (rst_n && bus.o_wr_valid) begin
      if (wq.size() == 0) begin
        n_checks++;
        $display("FAIL wr_unexpected: got addr %0h data %0h expected no write", bus.o_wr_addr, bus.o_wr_data);
      end else begin
        check("wr_commit", {bus.o_wr_addr, bus.o_wr_data}, wq.pop_front());
      end
    end
  end

  task automatic clks(input int unsigned n);
    repeat (n) @(negedge clk_in);
  endtask

  task automatic shift_bits(input bit [15:0] word, input int unsigned nbits, output bit [7:0] rdata);
    rdata = '0;
    for (int unsigned i = 0; i < nbits; i++) begin
      bus.i_sda = word[15-i];
      clks(HALF);
      if (i >= 8) rdata = {rdata[6:0], bus.o_sda};
      if (i == 7)  dir_pre = bus.o_sda_dir;
      if (i == 11) dir_mid = bus.o_sda_dir;
      bus.i_sclk = 1'b1;
      clks(HALF);
      bus.i_sclk = 1'b0;
    end
  endtask

  task automatic spi_frame(input bit rw, input bit [6:0] addr, input bit [7:0] wdata,
                           input int unsigned nbits, output bit [7:0] rdata);
    bus.i_sen_n = 1'b0;
    clks(4);
    shift_bits({rw, addr, wdata}, nbits, rdata);
    clks(HALF);
    dir_end = bus.o_sda_dir;
    bus.i_sen_n = 1'b1;
    clks(HALF);
    dir_post = bus.o_sda_dir;
    clks(4);
  endtask

  task automatic do_write(input bit [6:0] addr, input bit [7:0] data);
    bit [7:0] unused;
    wq.push_back({addr, data});
    spi_frame(1'b0, addr, data, 16, unused);
  endtask

  task automatic do_read(input bit [6:0] addr, input bit [7:0] exp);
    bit [7:0] got;
    rq.push_back(exp);
    spi_frame(1'b1, addr, 8'h00, 16, got);
    check($sformatf("rd_%02h", addr), got, rq.pop_front());
  endtask

  vec_t tbl[14];
  bit [7:0] scratch;
  int unsigned soft_before;
`ifdef AD9122_SPI_SLV_ERR_CNT_EN
  logic [7:0] err_before;
`endif

  initial begin
    tbl[0]  = '{1'b1, 7'h08, 8'h00, 8'h00};
    tbl[1]  = '{1'b0, 7'h08, 8'hA0, 8'h00};
    tbl[2]  = '{1'b1, 7'h08, 8'hA0, 8'h00};
    tbl[3]  = '{1'b0, 7'h7F, 8'h3C, 8'h00};
    tbl[4]  = '{1'b1, 7'h7F, 8'h3C, 8'h00};
    tbl[5]  = '{1'b0, 7'h01, 8'hFF, 8'h00};
    tbl[6]  = '{1'b1, 7'h01, 8'hFF, 8'h00};
    tbl[7]  = '{1'b1, 7'h19, 8'h1F, 8'h1F};
    tbl[8]  = '{1'b0, 7'h19, 8'h55, 8'h1F};
    tbl[9]  = '{1'b1, 7'h19, 8'h1F, 8'h1F};
    tbl[10] = '{1'b1, 7'h19, 8'hC3, 8'hC3};
    tbl[11] = '{1'b0, 7'h00, 8'h12, 8'hC3};
    tbl[12] = '{1'b1, 7'h00, 8'h12, 8'hC3};
    tbl[13] = '{1'b1, 7'h08, 8'hA0, 8'hC3};

    bus.i_sclk = 1'b0;
    bus.i_sen_n = 1'b1;
    bus.i_sda = 1'b0;
    bus.i_fifo_status = 8'h00;
    rst_n = 1'b0;
    clks(5);
    rst_n = 1'b1;
    clks(8);
    check("reset_outputs", {bus.o_sda, bus.o_sda_dir, bus.o_wr_valid, bus.o_soft_rst,
                            bus.o_wr_addr, bus.o_wr_data}, 32'h0);
`ifdef AD9122_SPI_SLV_ERR_CNT_EN
    check("reset_err_cnt", bus.o_err_cnt, 32'h0);
`endif

    for (int unsigned i = 0; i < 14; i++) begin
      bus.i_fifo_status = tbl[i].fifo;
      if (tbl[i].rw) do_read(tbl[i].addr, tbl[i].data);
      else           do_write(tbl[i].addr, tbl[i].data);
      if (i == 2) begin
        check("dir_before_8th_fall", dir_pre, 1'b0);
        check("dir_during_read", dir_mid, 1'b1);
        check("dir_before_sen_high", dir_end, 1'b1);
        check("dir_after_sen_high", dir_post, 1'b0);
      end
    end

    // Soft reset clears the file and shows a 4-cycle pulse.
    do_write(7'h16, 8'h02);
    do_read(7'h16, 8'h02);
    soft_before = soft_cycles;
    do_write(7'h00, 8'h80);
    check("soft_rst_len", soft_cycles - soft_before, 32'd4);
    do_read(7'h16, 8'h00);
    do_read(7'h00, 8'h00);
    do_read(7'h7F, 8'h00);

    // Align request: old value first, ack after the timer, cancel on 0x00.
    do_write(7'h18, 8'h02);
    do_read(7'h18, 8'h02);
    clks(ALIGN_LAT_TB + 50);
    do_read(7'h18, 8'h07);
    do_write(7'h18, 8'h00);
    do_read(7'h18, 8'h00);
    do_write(7'h18, 8'h02);
    do_write(7'h18, 8'h00);
    clks(ALIGN_LAT_TB + 50);
    do_read(7'h18, 8'h00);

    // Frame aborted after 12 bits of a write: no commit, register kept.
    do_write(7'h30, 8'h5A);
`ifdef AD9122_SPI_SLV_ERR_CNT_EN
    err_before = bus.o_err_cnt;
`endif
    bus.i_sen_n = 1'b0;
    clks(4);
    shift_bits({1'b0, 7'h30, 8'hFF}, 12, scratch);
    clks(HALF);
    bus.i_sen_n = 1'b1;
    clks(HALF + 8);
    do_read(7'h30, 8'h5A);
`ifdef AD9122_SPI_SLV_ERR_CNT_EN
    check("err_cnt_abort", bus.o_err_cnt, {24'h0, err_before + 8'd1});
`endif

    // Reset pulse in the middle of a read data phase.
    bus.i_sen_n = 1'b0;
    clks(4);
    shift_bits({1'b1, 7'h30, 8'h00}, 10, scratch);
    clks(4);
    check("dir_in_rdata", bus.o_sda_dir, 1'b1);
    rst_n = 1'b0;
    clks(1);
    check("dir_after_reset", bus.o_sda_dir, 1'b0);
    rst_n = 1'b1;
    clks(4);
    bus.i_sen_n = 1'b1;
    clks(HALF);
    do_read(7'h30, 8'h00);
    do_write(7'h30, 8'h11);
    do_read(7'h30, 8'h11);

    check("wr_queue_drained", wq.size(), 32'd0);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule
